// File: rtl/dram_port_ctrl.sv
// Per-core DRAM port sequencer: buffers load/store requests in a small FIFO and
// drives them onto one registered-read DRAM port, returning load data as a pulse.
//
// state   | meaning
// IDLE    | waiting for a buffered request; pops the head when one exists
// ISSUE   | port driven for one cycle; DRAM samples it at the closing edge
// CAPTURE | load only: DRAM read data is valid, latched into resp_rdata
module dram_port_ctrl #(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 1025
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        err,
  output logic        busy,
  output logic        mem_write_en,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL  = (PW+1)'(DEPTH);
  localparam logic [16:0] LIMIT = 17'(MEM_WORDS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  logic [15:0]      fifo_addr [DEPTH];
  logic [15:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] fifo_we;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [1:0]       state;

  logic in_range;
  logic accept;
  logic push;
  logic pop;

  assign in_range  = {1'b0, req_addr} < LIMIT;
  assign req_ready = (count != FULL);
  assign accept    = req_valid && req_ready;
  assign push      = accept && in_range;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign busy      = (count != '0) || (state != S_IDLE);

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= req_addr;
      fifo_data[wr_ptr] <= req_wdata;
      fifo_we[wr_ptr]   <= req_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      err          <= 1'b0;
    end else begin
      err        <= accept && !in_range;
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            mem_addr     <= fifo_addr[rd_ptr];
            mem_data_in  <= fifo_data[rd_ptr];
            mem_write_en <= fifo_we[rd_ptr];
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // mem_write_en still carries the request type during ISSUE
          mem_write_en <= 1'b0;
          state        <= mem_write_en ? S_IDLE : S_CAPTURE;
        end
        S_CAPTURE: begin
          resp_rdata <= mem_data_out;
          resp_valid <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_ctrl.sv
// Bench for dram_port_ctrl: DRAM model plus a transaction-level reference that
// schedules each request by arithmetic and is compared against the DUT every cycle.
module tb_dram_port_ctrl;
  localparam int DEPTH     = 4;
  localparam int MEM_WORDS = 1025;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        err;
  logic        busy;
  logic        mem_write_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out = '0;

  always #5 clk = ~clk;

  dram_port_ctrl #(.DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .err(err), .busy(busy),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // DRAM: registered read, write on the sampling edge
  logic [15:0] dram [MEM_WORDS] = '{default: 16'h0};
  always @(posedge clk) begin
    if (mem_write_en && int'(mem_addr) < MEM_WORDS) dram[mem_addr] <= mem_data_in;
    mem_data_out <= (int'(mem_addr) < MEM_WORDS) ? dram[mem_addr] : 16'h0;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=0x%0h expected=0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference: FIFO as a queue, the sequencer as "next free edge" arithmetic.
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  req_t        q[$];
  logic [15:0] mref [MEM_WORDS] = '{default: 16'h0};
  int          cyc = 0;
  int          free_at = 0;
  int          resp_due = -1;
  logic [15:0] resp_val = '0;
  bit          started = 0;
  logic        e_resp = 0, e_err = 0, e_wen = 0;
  logic [15:0] e_addr = '0, e_data = '0, e_rdata = '0;

  always @(posedge clk) begin
    req_t r;
    bit   ready_pre;
    cyc++;
    if (!rst_n) begin
      q.delete();
      free_at  = cyc + 1;
      resp_due = -1;
      e_resp = 0; e_err = 0; e_wen = 0;
      e_addr = '0; e_data = '0; e_rdata = '0;
      started = 1;
    end else begin
      ready_pre = (q.size() < DEPTH);
      e_resp = (resp_due == cyc);
      if (e_resp) e_rdata = resp_val;
      e_wen = 0;
      if (cyc >= free_at && q.size() > 0) begin
        r = q.pop_front();
        e_addr = r.addr;
        e_data = r.data;
        e_wen  = r.we;
        if (r.we) begin
          mref[r.addr] = r.data;
          free_at = cyc + 2;
        end else begin
          resp_val = mref[r.addr];
          resp_due = cyc + 2;
          free_at  = cyc + 3;
        end
      end
      e_err = 0;
      if (req_valid && ready_pre) begin
        if (int'(req_addr) < MEM_WORDS) q.push_back('{req_we, req_addr, req_wdata});
        else e_err = 1;
      end
    end
  end

  int          resp_cnt = 0, err_cnt = 0, wen_cnt = 0, notready_cnt = 0;
  logic [15:0] obs[$];

  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", int'(req_ready), int'(q.size() < DEPTH));
      chk("busy", int'(busy), int'(q.size() != 0 || cyc < free_at - 1));
      chk("resp_valid", int'(resp_valid), int'(e_resp));
      chk("resp_rdata", int'(resp_rdata), int'(e_rdata));
      chk("err", int'(err), int'(e_err));
      chk("mem_write_en", int'(mem_write_en), int'(e_wen));
      chk("mem_addr", int'(mem_addr), int'(e_addr));
      chk("mem_data_in", int'(mem_data_in), int'(e_data));
      if (resp_valid) begin
        resp_cnt++;
        obs.push_back(resp_rdata);
      end
      if (err) err_cnt++;
      if (mem_write_en) wen_cnt++;
      if (!req_ready) notready_cnt++;
    end
  end

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Holds the request until the handshake edge; leaves req_valid high.
  task automatic send(input bit we, input logic [15:0] addr, input logic [15:0] data);
    bit ok;
    int t = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    forever begin
      ok = req_ready;
      @(negedge clk);
      if (ok) break;
      t++;
      if (t > 50) begin
        checks++;
        failures++;
        $display("FAIL send_timeout addr=0x%0h got=no_handshake expected=handshake", addr);
        break;
      end
    end
  endtask

  initial begin
    int base, r0, e0, w0, k, nr0;
    logic [15:0] exp3 [4];

    // 1: reset held with req_valid asserted
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd5; req_wdata = 16'd9;
    repeat (2) @(negedge clk);
    chk("t1_resp_valid", int'(resp_valid), 0);
    chk("t1_err", int'(err), 0);
    chk("t1_busy", int'(busy), 0);
    chk("t1_mem_write_en", int'(mem_write_en), 0);
    chk("t1_mem_addr", int'(mem_addr), 0);
    chk("t1_mem_data_in", int'(mem_data_in), 0);
    chk("t1_resp_rdata", int'(resp_rdata), 0);
    rst_n = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("t1_req_ready", int'(req_ready), 1);
    chk("t1_no_push_busy", int'(busy), 0);

    // 2: store then load, latency and data
    w0 = wen_cnt;
    send(1, 16'd10, 16'd85);
    idle(4);
    chk("t2_store_pulses", wen_cnt - w0, 1);
    chk("t2_dram10", int'(dram[10]), 85);
    send(0, 16'd10, 16'd0);
    req_valid = 1'b0;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        k = i;
        break;
      end
    end
    chk("t2_latency", k, 3);
    chk("t2_rdata", int'(resp_rdata), 85);
    idle(4);

    // 3: back-to-back stores then loads, FIFO fills
    base = obs.size(); r0 = resp_cnt; nr0 = notready_cnt;
    exp3[0] = 16'd3; exp3[1] = 16'd3; exp3[2] = 16'd3; exp3[3] = 16'd12;
    for (int i = 0; i < 4; i++) send(1, 16'(i), exp3[i]);
    for (int i = 0; i < 4; i++) send(0, 16'(i), 16'h0);
    idle(20);
    chk("t3_resp_count", resp_cnt - r0, 4);
    chk("t3_saw_full", int'(notready_cnt > nr0), 1);
    for (int i = 0; i < 4; i++)
      if (base + i < obs.size()) chk("t3_order", int'(obs[base + i]), int'(exp3[i]));

    // 4: address range boundary
    send(1, 16'd1024, 16'h1234);
    idle(4);
    base = obs.size(); r0 = resp_cnt; e0 = err_cnt; w0 = wen_cnt;
    send(0, 16'd1025, 16'h0);
    send(0, 16'd1024, 16'h0);
    idle(10);
    chk("t4_err_pulses", err_cnt - e0, 1);
    chk("t4_resp_count", resp_cnt - r0, 1);
    chk("t4_no_write", wen_cnt - w0, 0);
    if (base < obs.size()) chk("t4_rdata", int'(obs[base]), 16'h1234);

    // 5: wrap-around over 3*DEPTH requests
    base = obs.size(); r0 = resp_cnt;
    for (int j = 0; j < 3 * DEPTH / 2; j++) begin
      send(1, 16'(100 + j), 16'(16'hA000 + j));
      send(0, 16'(100 + j), 16'h0);
    end
    idle(30);
    chk("t5_resp_count", resp_cnt - r0, 3 * DEPTH / 2);
    for (int j = 0; j < 3 * DEPTH / 2; j++)
      if (base + j < obs.size()) chk("t5_data", int'(obs[base + j]), 16'hA000 + j);

    // 6: reset while a store to 7 is in ISSUE with two loads buffered
    r0 = resp_cnt;
    send(1, 16'd6, 16'h0606);
    send(1, 16'd7, 16'h0707);
    send(0, 16'd20, 16'h0);
    send(0, 16'd21, 16'h0);
    chk("t6_in_issue_store", int'(mem_write_en && mem_addr == 16'd7), 1);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    chk("t6_dram7", int'(dram[7]), 16'h0707);
    chk("t6_no_resp", resp_cnt - r0, 0);
    chk("t6_busy", int'(busy), 0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1020, 1030))
                                              : 16'($urandom_range(0, 15));
      req_wdata = 16'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b1;
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
